// File: rtl/zeroriscy_defines.sv
// Shared encodings for the sequential multiply/divide unit.
// Op codes and FSM states used by zeroriscy_multdiv_seq.
package zeroriscy_defines;

   localparam int MD_OP_WIDTH = 2;

   typedef enum logic [MD_OP_WIDTH-1:0] {
      MD_MUL   = 2'd0,
      MD_MULHU = 2'd1,
      MD_DIVU  = 2'd2,
      MD_REMU  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/zeroriscy_multdiv_seq.sv
// Iterative unsigned multiply / divide, one bit per cycle,
// borrowing the main ALU adder through the alu_* ports.
module zeroriscy_multdiv_seq
   import zeroriscy_defines::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic        kill_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] operand_a_i,
   input  logic [31:0] operand_b_i,
   input  logic [33:0] alu_adder_ext_i,
   output logic [32:0] alu_operand_a_o,
   output logic [32:0] alu_operand_b_o,
   output logic        alu_en_o,
   output logic        busy_o,
   output logic        valid_o,
   output logic [31:0] result_o
);

   md_state_e   state_q, state_n;
   md_op_e      op_q, op_n;
   logic [4:0]  cnt_q, cnt_n;
   logic [31:0] acc_q, acc_n;
   logic [31:0] opa_q, opa_n;
   logic [31:0] opb_q, opb_n;
   logic [31:0] result_q;
   logic [31:0] res_d;
   logic [32:0] sum;
   logic [32:0] rem_sh;
   logic        is_div;
   logic        qbit;
   logic        unused_ok;

   assign sum       = alu_adder_ext_i[33:1];
   assign unused_ok = alu_adder_ext_i[0];

   assign is_div = (op_q == MD_DIVU) || (op_q == MD_REMU);
   assign rem_sh = {acc_q, opa_q[31]};
   // rem_sh >= 2^32 always exceeds the divisor; otherwise the
   // adder carry-out tells whether rem_sh[31:0] >= divisor.
   assign qbit   = rem_sh[32] | sum[32];

   always_comb begin
      res_d = opa_q;
      unique case (op_q)
         MD_MULHU, MD_REMU: res_d = acc_q;
         default:           res_d = opa_q;
      endcase
   end

   always_comb begin
      state_n         = state_q;
      op_n            = op_q;
      cnt_n           = cnt_q;
      acc_n           = acc_q;
      opa_n           = opa_q;
      opb_n           = opb_q;
      alu_en_o        = 1'b0;
      alu_operand_a_o = '0;
      alu_operand_b_o = '0;
      unique case (state_q)
         MD_IDLE: begin
            if (start_i && !kill_i) begin
               op_n    = md_op_e'(op_i);
               opa_n   = operand_a_i;
               opb_n   = operand_b_i;
               acc_n   = '0;
               cnt_n   = 5'd31;
               state_n = MD_CALC;
               // Divide by zero: preload the architectural answers
               if (op_i[1] && (operand_b_i == '0)) begin
                  opa_n   = '1;
                  acc_n   = operand_a_i;
                  state_n = MD_DONE;
               end
            end
         end
         MD_CALC: begin
            alu_en_o = 1'b1;
            cnt_n    = cnt_q - 5'd1;
            if (is_div) begin
               alu_operand_a_o = {rem_sh[31:0], 1'b1};
               alu_operand_b_o = {~opb_q, 1'b1};
               acc_n = qbit ? sum[31:0] : rem_sh[31:0];
               opa_n = {opa_q[30:0], qbit};
            end else begin
               alu_operand_a_o = {acc_q, 1'b0};
               alu_operand_b_o = {(opa_q[0] ? opb_q : 32'd0), 1'b0};
               acc_n = sum[32:1];
               opa_n = {sum[0], opa_q[31:1]};
            end
            if (kill_i) begin
               state_n = MD_IDLE;
            end else if (cnt_q == 5'd0) begin
               state_n = MD_DONE;
            end
         end
         MD_DONE: begin
            state_n = MD_IDLE;
         end
         default: begin
            state_n = MD_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= MD_IDLE;
         op_q     <= MD_MUL;
         cnt_q    <= '0;
         acc_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_n;
         op_q    <= op_n;
         cnt_q   <= cnt_n;
         acc_q   <= acc_n;
         opa_q   <= opa_n;
         opb_q   <= opb_n;
         if (valid_o) begin
            result_q <= res_d;
         end
      end
   end

   assign busy_o   = (state_q == MD_CALC) || (state_q == MD_DONE);
   assign valid_o  = (state_q == MD_DONE) && !kill_i;
   assign result_o = valid_o ? res_d : result_q;

endmodule

// File: tb/tb_zeroriscy_multdiv_seq.sv
// Scoreboard bench for zeroriscy_multdiv_seq with a behavioural
// model of the shared ALU adder.
module tb_zeroriscy_multdiv_seq;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic        kill_i;
   logic [1:0]  op_i;
   logic [31:0] operand_a_i;
   logic [31:0] operand_b_i;
   logic [33:0] alu_adder_ext_i;
   logic [32:0] alu_operand_a_o;
   logic [32:0] alu_operand_b_o;
   logic        alu_en_o;
   logic        busy_o;
   logic        valid_o;
   logic [31:0] result_o;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc;
   int          checks;
   int          errors;
   logic [31:0] last_res;

   zeroriscy_multdiv_seq dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_i         (start_i),
      .kill_i          (kill_i),
      .op_i            (op_i),
      .operand_a_i     (operand_a_i),
      .operand_b_i     (operand_b_i),
      .alu_adder_ext_i (alu_adder_ext_i),
      .alu_operand_a_o (alu_operand_a_o),
      .alu_operand_b_o (alu_operand_b_o),
      .alu_en_o        (alu_en_o),
      .busy_o          (busy_o),
      .valid_o         (valid_o),
      .result_o        (result_o)
   );

   assign alu_adder_ext_i = {1'b0, alu_operand_a_o} + {1'b0, alu_operand_b_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every valid pulse must match the oldest expectation
   always @(negedge clk) begin
      if (valid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got 0x%08h at cycle %0d, expected none",
                     result_o, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_result"}, result_o, e.res);
            check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
         end
      end
      if (alu_en_o == 1'b0) begin
         if (alu_operand_a_o != '0 || alu_operand_b_o != '0) begin
            checks++;
            errors++;
            $display("FAIL alu_ops_idle: got a=0x%09h b=0x%09h, expected 0",
                     alu_operand_a_o, alu_operand_b_o);
         end
      end
   end

   // Caller is #1 after a rising edge; start is sampled at the next one.
   task automatic kick(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
      start_i     = 1'b1;
      op_i        = op;
      operand_a_i = a;
      operand_b_i = b;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic issue(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat,
                        input int en_cycles);
      exp_t e;
      int   en_cnt;
      int   n;
      e.res  = res;
      e.cyc  = cyc + lat;
      e.name = name;
      exp_q.push_back(e);
      kick(op, a, b);
      en_cnt = 0;
      n      = 0;
      while (busy_o && n < 40) begin
         if (alu_en_o) en_cnt++;
         @(posedge clk);
         #1;
         n++;
      end
      if (busy_o) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy after %0d cycles, expected idle", name, n);
      end
      check({name, "_alu_en"}, 32'(en_cnt), 32'(en_cycles));
      last_res = res;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      start_i     = 1'b1;
      kill_i      = 1'b0;
      op_i        = 2'd0;
      operand_a_i = 32'd5;
      operand_b_i = 32'd3;
      last_res    = '0;
      repeat (3) @(posedge clk);
      #1;
      start_i = 1'b0;
      rst_n   = 1'b1;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_alu_en", 32'(alu_en_o), 32'd0);
      check("rst_result", result_o, 32'd0);
      @(posedge clk);
      #1;
      check("rst_start_ignored", 32'(busy_o), 32'd0);

      issue("mul_7x6", 2'd0, 32'd7, 32'd6, 32'h0000002A, 33, 32);
      issue("mul_ff", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 32);
      issue("mulhu_ff", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32);
      issue("mul_2p16", 2'd0, 32'h00010000, 32'h00010000, 32'h00000000, 33, 32);
      issue("mulhu_2p16", 2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 33, 32);
      issue("divu_100_7", 2'd2, 32'd100, 32'd7, 32'h0000000E, 33, 32);
      issue("remu_100_7", 2'd3, 32'd100, 32'd7, 32'h00000002, 33, 32);
      issue("divu_msb_1", 2'd2, 32'h80000000, 32'd1, 32'h80000000, 33, 32);
      issue("divu_big", 2'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 33, 32);
      issue("remu_big", 2'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32);
      issue("divu_half", 2'd2, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 33, 32);
      issue("remu_half", 2'd3, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 33, 32);
      issue("divu_by0", 2'd2, 32'h00001234, 32'd0, 32'hFFFFFFFF, 1, 0);
      issue("remu_by0", 2'd3, 32'h00001234, 32'd0, 32'h00001234, 1, 0);

      // Kill a MUL in cycle 10
      kick(2'd0, 32'd9, 32'd9);
      repeat (9) @(posedge clk);
      #1;
      kill_i = 1'b1;
      @(posedge clk);
      #1;
      kill_i = 1'b0;
      check("kill_busy", 32'(busy_o), 32'd0);
      check("kill_valid", 32'(valid_o), 32'd0);
      check("kill_result_held", result_o, last_res);
      issue("mul_after_kill", 2'd0, 32'd3, 32'd5, 32'h0000000F, 33, 32);

      // Kill and start together in IDLE: start dropped
      kill_i = 1'b1;
      kick(2'd0, 32'd2, 32'd2);
      kill_i = 1'b0;
      check("kill_start_idle", 32'(busy_o), 32'd0);

      // Reset in cycle 5 of a DIVU, with start held during reset
      kick(2'd2, 32'd1000, 32'd3);
      repeat (4) @(posedge clk);
      #1;
      rst_n       = 1'b0;
      start_i     = 1'b1;
      op_i        = 2'd0;
      operand_a_i = 32'd4;
      operand_b_i = 32'd4;
      @(posedge clk);
      #1;
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_valid", 32'(valid_o), 32'd0);
      check("midrst_alu_en", 32'(alu_en_o), 32'd0);
      check("midrst_alu_a", alu_operand_a_o[31:0], 32'd0);
      check("midrst_result", result_o, 32'd0);
      start_i = 1'b0;
      rst_n   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_idle", 32'(busy_o), 32'd0);

      issue("divu_after_rst", 2'd2, 32'd1000, 32'd3, 32'd333, 33, 32);
      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
